// File: rtl/gf163_pkg.sv
// Field constants and shared types for GF(2^163) reduction,
// f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package gf163_pkg;

  localparam int unsigned M      = 163;
  localparam int unsigned PROD_W = 325;

  // Low-order taps of the pentanomial (x^163 is folded away).
  localparam int unsigned TAP_A = 7;
  localparam int unsigned TAP_B = 6;
  localparam int unsigned TAP_C = 3;
  localparam int unsigned TAP_D = 0;

  localparam int unsigned TAP_MAX = TAP_A;

  // Width of the high word folded in the first pass.
  localparam int unsigned FOLD_W  = PROD_W - M;
  // Bits that spill above x^162 after the first pass.
  localparam int unsigned SPILL_W = FOLD_W + TAP_MAX - M;

  typedef enum logic [1:0] {
    StIdle,
    StFold1,
    StFold2,
    StDone
  } state_e;

endpackage

// File: rtl/gf163_fold.sv
// Combinational fold: hi_i * (x^7 + x^6 + x^3 + 1) over GF(2), carry-free.
module gf163_fold
  import gf163_pkg::*;
#(
  parameter int unsigned HiW = 1
) (
  input  logic [HiW-1:0]         hi_i,
  output logic [HiW+TAP_MAX-1:0] prod_o
);

  localparam int unsigned OutW = HiW + TAP_MAX;

  logic [OutW-1:0] hi_ext;

  assign hi_ext = {{TAP_MAX{1'b0}}, hi_i};
  assign prod_o = (hi_ext << TAP_A) ^ (hi_ext << TAP_B) ^
                  (hi_ext << TAP_C) ^ (hi_ext << TAP_D);

endmodule

// File: rtl/gf163_reduce.sv
// Reduces a 325-bit GF(2)[x] product modulo f(x) = x^163+x^7+x^6+x^3+1 in two
// fold passes. Optional saturating handshake counter red_count_o is present
// only when GF163_REDUCE_CNT_EN is defined.
module gf163_reduce
  import gf163_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PROD_W-1:0] c_in_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
`ifdef GF163_REDUCE_CNT_EN
  output logic [15:0]       red_count_o,
`endif
  output logic [M-1:0]      y_o
);

  localparam int unsigned F1W = FOLD_W + TAP_MAX;
  localparam int unsigned F2W = SPILL_W + TAP_MAX;

  state_e            state_q;
  logic [PROD_W-1:0] acc_q;
  logic [F1W-1:0]    fold1_prod;
  logic [F2W-1:0]    fold2_prod;

  gf163_fold #(
    .HiW (FOLD_W)
  ) u_fold1 (
    .hi_i   (acc_q[PROD_W-1:M]),
    .prod_o (fold1_prod)
  );

  gf163_fold #(
    .HiW (SPILL_W)
  ) u_fold2 (
    .hi_i   (acc_q[M+SPILL_W-1:M]),
    .prod_o (fold2_prod)
  );

  // Control FSM and accumulator: load, fold high word, fold spill, hold result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            acc_q   <= c_in_i;
            state_q <= StFold1;
          end
        end
        StFold1: begin
          acc_q   <= {{(PROD_W-F1W){1'b0}},
                      ({{(F1W-M){1'b0}}, acc_q[M-1:0]} ^ fold1_prod)};
          state_q <= StFold2;
        end
        StFold2: begin
          acc_q   <= {{(PROD_W-M){1'b0}},
                      (acc_q[M-1:0] ^ {{(M-F2W){1'b0}}, fold2_prod})};
          state_q <= StDone;
        end
        StDone: begin
          if (out_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign y_o         = acc_q[M-1:0];

`ifdef GF163_REDUCE_CNT_EN
  logic [15:0] cnt_q;

  // Count completed output handshakes, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if ((state_q == StDone) && out_ready_i && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign red_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_gf163_reduce.sv
// Self-checking bench for gf163_reduce with a scoreboard of expected results.
module tb_gf163_reduce;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [324:0] c_in;
  logic         out_valid;
  logic         out_ready;
  logic [162:0] y;
`ifdef GF163_REDUCE_CNT_EN
  logic [15:0]  red_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  longint cyc = 0;
  logic [162:0] sb[$];

  gf163_reduce u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .c_in_i      (c_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
`ifdef GF163_REDUCE_CNT_EN
    .red_count_o (red_count),
`endif
    .y_o         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, failed %0d so far", n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [324:0] rand_wide();
    logic [324:0] r;
    r = '0;
    for (int i = 0; i < 11; i++) r = {r[292:0], $urandom()};
    return r;
  endfunction

  // Carry-less schoolbook multiply, stands in for the Karatsuba tree.
  function automatic logic [324:0] clmul(input logic [162:0] a, input logic [162:0] b);
    logic [324:0] r;
    r = '0;
    for (int i = 0; i < 163; i++) if (b[i]) r = r ^ ({162'b0, a} << i);
    return r;
  endfunction

  // Polynomial long division by f(x).
  function automatic logic [162:0] mod_f(input logic [324:0] c);
    logic [324:0] r;
    logic [324:0] f;
    r = c;
    f = '0;
    f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
    for (int i = 324; i >= 163; i--) if (r[i]) r = r ^ (f << (i - 163));
    return r[162:0];
  endfunction

  // Present one product for one edge and push its expected result.
  task automatic send(input logic [324:0] c, input logic [162:0] exp, output longint acc_cyc);
    in_valid = 1'b1;
    c_in     = c;
    sb.push_back(exp);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    c_in     = rand_wide();
  endtask

  // Wait (bounded) for out_valid; lat counts cycles with the accepting edge's cycle as 1.
  task automatic collect(output logic [162:0] yv, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    yv  = 'x;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        ok  = 1'b1;
        lat = k;
        yv  = y;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; c_in = rand_wide(); out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b expected 0", out_valid);
    end
    n_tests++;
    if (y !== '0) begin
      n_fail++; $display("FAIL reset_y got %h expected 0", y);
    end
`ifdef GF163_REDUCE_CNT_EN
    n_tests++;
    if (red_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_red_count got %0d expected 0", red_count);
    end
`endif
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle_after got in_ready %b expected 1", in_ready);
    end
  endtask

  task automatic test_x163();
    logic [324:0] c; logic [162:0] yv, exp; int lat; bit ok; longint t;
    c = '0; c[163] = 1'b1;
    out_ready = 1'b1;
    send(c, 163'hC9, t);
    collect(yv, lat, ok);
    exp = sb.pop_front();
    n_tests++;
    if (!ok || lat != 3) begin
      n_fail++; $display("FAIL x163_latency got %0d (seen %0b) expected 3", lat, ok);
    end
    n_tests++;
    if (yv !== exp) begin
      n_fail++; $display("FAIL x163_y got %h expected %h", yv, exp);
    end
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL x163_return_idle got in_ready %b out_valid %b expected 1 0",
                         in_ready, out_valid);
    end
  endtask

  task automatic test_x324();
    logic [324:0] c; logic [162:0] yv, exp; int lat; bit ok; longint t;
    c = '0; c[324] = 1'b1;
    exp = '0; exp[161] = 1'b1; exp[12:0] = 13'h1422;
    send(c, exp, t);
    collect(yv, lat, ok);
    exp = sb.pop_front();
    n_tests++;
    if (!ok || yv !== exp) begin
      n_fail++; $display("FAIL x324_y got %h expected %h", yv, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic [162:0] yv, exp; int lat; bit ok; longint t;
    send('0, '0, t);
    collect(yv, lat, ok);
    exp = sb.pop_front();
    n_tests++;
    if (!ok || yv !== exp) begin
      n_fail++; $display("FAIL zero_y got %h expected %h", yv, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [324:0] c; logic [162:0] yv, exp; int lat; bit ok; longint t; int bad;
    c = rand_wide();
    out_ready = 1'b0;
    send(c, mod_f(c), t);
    collect(yv, lat, ok);
    exp = sb.pop_front();
    n_tests++;
    if (!ok || yv !== exp) begin
      n_fail++; $display("FAIL bp_y got %h expected %h", yv, exp);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; c_in = rand_wide();
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== exp) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_hold got %0d unstable cycles expected 0", bad);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got in_ready %b out_valid %b expected 1 0",
                         in_ready, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_ignored_input got %0d busy cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_abort();
    logic [324:0] c; longint t; int bad;
    c = rand_wide();
    send(c, mod_f(c), t);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== '0) begin
      n_fail++; $display("FAIL abort_state got in_ready %b out_valid %b y %h expected 1 0 0",
                         in_ready, out_valid, y);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL abort_no_result got %0d valid cycles expected 0", bad);
    end
`ifdef GF163_REDUCE_CNT_EN
    n_tests++;
    if (red_count !== 16'd0) begin
      n_fail++; $display("FAIL abort_red_count got %0d expected 0", red_count);
    end
`endif
  endtask

`ifdef GF163_REDUCE_CNT_EN
  task automatic test_count();
    logic [324:0] c; logic [162:0] yv, exp; int lat; bit ok; longint t;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c = rand_wide();
      send(c, mod_f(c), t);
      collect(yv, lat, ok);
      exp = sb.pop_front();
      n_tests++;
      if (!ok || yv !== exp) begin
        n_fail++; $display("FAIL count_y[%0d] got %h expected %h", i, yv, exp);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (red_count !== 16'd3) begin
      n_fail++; $display("FAIL count_value got %0d expected 3", red_count);
    end
  endtask
`endif

  task automatic test_back_to_back(input int n);
    logic [324:0] w; logic [162:0] a, b, yv, exp; int lat; bit ok; longint t, prev;
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      w = rand_wide(); a = w[162:0];
      w = rand_wide(); b = w[162:0];
      w = clmul(a, b);
      send(w, mod_f(w), t);
      collect(yv, lat, ok);
      exp = sb.pop_front();
      n_tests++;
      if (!ok || lat != 3 || yv !== exp) begin
        n_fail++; $display("FAIL random[%0d] got y %h lat %0d expected y %h lat 3",
                           i, yv, lat, exp);
      end
      if (i > 0) begin
        n_tests++;
        if (t - prev != 4) begin
          n_fail++; $display("FAIL throughput[%0d] got %0d cycles expected 4", i, t - prev);
        end
      end
      prev = t;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; c_in = '0;
    test_reset();
    test_x163();
    test_x324();
    test_zero();
    test_backpressure();
    test_reset_abort();
`ifdef GF163_REDUCE_CNT_EN
    test_count();
`endif
    test_back_to_back(10000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gf163_reduce.md
GF163_REDUCE -- requirements
Module: gf163_reduce

Interface
REQ-001 Parameters: none; field constants SHALL come from gf163_pkg.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  c_in holds a valid unreduced product.
REQ-005 in_ready  output  1  block can accept a product.
REQ-006 c_in  input  325  unreduced GF(2)[x] product from the Karatsuba multiplier tree, bit i = coeff of x^i.
REQ-007 out_valid  output  1  y holds a reduced result.
REQ-008 out_ready  input  1  consumer accepts y.
REQ-009 y  output  163  c_in mod f(x), f = x^163+x^7+x^6+x^3+1.

Function
REQ-010 FSM states SHALL be IDLE, FOLD1, FOLD2, DONE; in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-011 IDLE: on in_valid&&in_ready, 325-bit acc SHALL load c_in and the state SHALL go to FOLD1; otherwise the state SHALL stay IDLE.
REQ-012 FOLD1: acc[168:0] SHALL load acc[162:0] XOR (h*(x^7+x^6+x^3+1)) with h = acc[324:163]; acc[324:169] SHALL clear; next state FOLD2.
REQ-013 FOLD2: acc[162:0] SHALL load acc[162:0] XOR (g*(x^7+x^6+x^3+1)) with g = acc[168:163]; acc[324:163] SHALL clear; next state DONE.
REQ-014 DONE: y SHALL equal acc[162:0]; on out_ready the state SHALL go to IDLE; otherwise y and out_valid SHALL hold stable.
REQ-015 Latency: out_valid SHALL rise exactly 3 cycles after the accepting edge; throughput SHALL be one result per 4 cycles with out_ready held high.
REQ-016 in_valid during FOLD1/FOLD2/DONE SHALL be ignored (in_ready low); c_in SHALL only be sampled on acceptance.
REQ-017 All arithmetic SHALL be carry-free XOR; no integer adders.
REQ-018 y SHALL be driven from acc in every state (don't-care outside DONE) and SHALL read zero after reset.

Reset
REQ-019 rst SHALL force state IDLE, acc zero, in_ready 1, out_valid 0, y zero on the next edge, overriding any handshake in that cycle.
REQ-020 rst asserted during FOLD1, FOLD2 or DONE SHALL abort the operation with no result emitted.

Configuration
REQ-021 With GF163_REDUCE_CNT_EN defined, a 16-bit output red_count SHALL exist: reset 0, +1 on each DONE&&out_ready handshake, saturating at 0xFFFF.
REQ-022 Without GF163_REDUCE_CNT_EN, the port and the counter SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-023 gf163_pkg SHALL hold M=163, PROD_W=325, the pentanomial tap constants (7,6,3,0) and the state enum type.
REQ-024 One sub-module gf163_fold (combinational: hi word x low-tap pentanomial -> XOR vector) SHALL be instantiated twice, once for each of FOLD1 and FOLD2.

Verification
REQ-025 c_in=1<<163, out_ready=1 -> y=0xC9, out_valid 3 cycles after accept.
REQ-026 c_in=1<<324 -> y = (1<<161)|0x1422 (exercises the second fold).
REQ-027 c_in=all zero, then c_in=random a*b from the KA tree -> y=0, then y matches the software mod-f reference over 10k random vectors.
REQ-028 out_ready held low for 5 cycles in DONE -> y/out_valid stable, in_ready low, new in_valid ignored; release -> IDLE next cycle.
REQ-029 rst pulsed in FOLD2 -> no out_valid, IDLE with in_ready=1 next cycle; with GF163_REDUCE_CNT_EN, red_count=0 after reset and =3 after three handshakes.
